muldiv_sequencer: RTL and testbench

//   Multi-cycle MULT/MULTU/DIV/DIVU engine with its HI/LO register pair, driven from the EX stage.

---
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage to HI/LO engine bus: operation request, ID hazard hint, and engine status/results.
interface muldiv_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic        kill;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        id_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, kill, src_a, src_b, id_md_use,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, kill, src_a, src_b, id_md_use,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Fixed-latency MULT/MULTU/DIV/DIVU engine owning HI/LO, with ID-stage stall generation.
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              sgn_q, sgn_d;

    logic              busy_c, go_c, md_op_c;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;

    assign busy_c  = (state_q != ST_IDLE);
    assign go_c    = bus.start & ~bus.kill & ~busy_c;
    assign md_op_c = (bus.op == OP_MULT) | (bus.op == OP_MULTU) |
                     (bus.op == OP_DIV)  | (bus.op == OP_DIVU);

    assign bus.busy  = busy_c;
    assign bus.stall = bus.id_md_use & (busy_c | (bus.start & ~bus.kill & md_op_c));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    // Datapath on latched operands; signed divide works on magnitudes so MIN/-1 cannot overflow.
    always_comb begin
        a_neg = sgn_q & a_q[XLEN-1];
        b_neg = sgn_q & b_q[XLEN-1];
        a_ext = {{XLEN{a_neg}}, a_q};
        b_ext = {{XLEN{b_neg}}, b_q};
        prod  = a_ext * b_ext;
        a_mag = a_neg ? XLEN'(-a_q) : a_q;
        b_mag = b_neg ? XLEN'(-b_q) : b_q;
        q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
        rem   = a_neg ? XLEN'(-r_mag) : r_mag;
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (go_c) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            sgn_d   = (bus.op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            sgn_d   = (bus.op == OP_DIV);
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = prod;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    // Divide by zero keeps the old HI/LO
                    if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at issue, compared when the engine goes idle.
module tb_muldiv_sequencer;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        stall_t, busy_t, stall_drop, stall_end;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Reference model: 64-bit signed/unsigned arithmetic, independent of the RTL datapath.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv, p, q, r;
        longint unsigned ua, ub, pu;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (o)
            OP_MULT:  begin p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_MULTU: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
            OP_DIV:   if (b != 0) begin q = sa / sbv; r = sa % sbv; m_lo = q[31:0]; m_hi = r[31:0]; end
            OP_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
            default:  ;
        endcase
    endtask

    // Drive one start cycle (T); operands are scrambled afterwards to expose missing latching.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic idu, input logic k);
        @(posedge clock); #1;
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        bus.id_md_use = idu; bus.kill = k;
        stall_drop = 1'b0;
        if (!k) begin
            model_apply(o, a, b);
            sb.push_back({m_hi, m_lo});
        end
        @(negedge clock);
        stall_t = bus.stall;
        busy_t  = bus.busy;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = OP_NONE;
        bus.src_a = $urandom; bus.src_b = $urandom;
    endtask

    // Count busy cycles from T+1, bounded; leaves the bench at the first idle negedge.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        @(negedge clock);
        while (bus.busy && cnt < 40) begin
            cnt++;
            if (!bus.stall) stall_drop = 1'b1;
            @(negedge clock);
        end
        stall_end = bus.stall;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = OP_NONE; bus.kill = 1'b0;
        bus.src_a = '0; bus.src_b = '0; bus.id_md_use = 1'b1;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        checks++; if ({bus.hi, bus.lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h_%h expected 0", bus.hi, bus.lo); end
        @(negedge clock); reset = 1'b1; bus.id_md_use = 1'b0;
    endtask

    task automatic test_mult;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL mult_busy_T: got %b expected 0", busy_t); end
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'hFFFFFFFF_FFFFFFFA) begin
            errors++; $display("FAIL mult_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_multu;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'h00000001_FFFFFFFE) begin
            errors++; $display("FAIL multu_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_div;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++; $display("FAIL div_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_idle(n);
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'h00000000_80000000) begin
            errors++; $display("FAIL div_overflow: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_divu_zero;
        issue(OP_DIVU, 32'd9, 32'd0, 1'b0, 1'b0);
        wait_idle(n);
        checks++; if (n != 10) begin errors++; $display("FAIL divu0_cycles: got %0d expected 10", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v) begin
            errors++; $display("FAIL divu0_unchanged: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_mthi_mtlo;
        issue(OP_MTHI, 32'h00001234, 32'd0, 1'b0, 1'b0);
        checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL mthi_busy_T: got %b expected 0", busy_t); end
        wait_idle(n);
        checks++; if (n != 0) begin errors++; $display("FAIL mthi_cycles: got %0d expected 0", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || bus.hi !== 32'h00001234) begin
            errors++; $display("FAIL mthi_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
        issue(OP_MTLO, 32'hCAFE0001, 32'd0, 1'b0, 1'b0);
        wait_idle(n);
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v) begin
            errors++; $display("FAIL mtlo_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_stall;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        checks++; if (stall_t !== 1'b1) begin errors++; $display("FAIL stall_T: got %b expected 1", stall_t); end
        wait_idle(n);
        checks++; if (n != 5 || stall_drop !== 1'b0) begin
            errors++; $display("FAIL stall_busy: got cycles=%0d dropped=%b expected 5/0", n, stall_drop); end
        checks++; if (stall_end !== 1'b0) begin errors++; $display("FAIL stall_T6: got %b expected 0", stall_end); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v) begin
            errors++; $display("FAIL stall_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
        bus.id_md_use = 1'b0;
    endtask

    task automatic test_kill;
        issue(OP_MULT, 32'h00000123, 32'h00000456, 1'b1, 1'b1);
        checks++; if (stall_t !== 1'b0) begin errors++; $display("FAIL kill_stall: got %b expected 0", stall_t); end
        wait_idle(n);
        checks++; if (n != 0) begin errors++; $display("FAIL kill_busy: got %0d expected 0", n); end
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL kill_hilo: got %h_%h expected %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        bus.id_md_use = 1'b0;
    endtask

    task automatic test_back_to_back;
        issue(OP_MULTU, 32'h10, 32'h10, 1'b1, 1'b0);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'hDEAD0000;
        @(negedge clock);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b expected 1", bus.stall); end
        @(posedge clock); #1;
        bus.start = 1'b0; bus.op = OP_NONE;
        wait_idle(n);
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_cycles: got %0d expected 4", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'h00000000_00000100) begin
            errors++; $display("FAIL b2b_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
        bus.id_md_use = 1'b0;
    endtask

    task automatic test_reset_abort;
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'd0) begin
            errors++; $display("FAIL abort_reset: got busy=%b hilo=%h_%h expected 0/0", bus.busy, bus.hi, bus.lo); end
        sb.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'd0) begin
            errors++; $display("FAIL abort_stays_idle: got busy=%b hilo=%h_%h expected 0/0", bus.busy, bus.hi, bus.lo); end
    endtask

    task automatic test_after_reset;
        issue(OP_MULT, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0);
        wait_idle(n);
        checks++; if (n != 5) begin errors++; $display("FAIL post_reset_cycles: got %0d expected 5", n); end
        exp_v = sb.pop_front();
        checks++; if ({bus.hi, bus.lo} !== exp_v || exp_v !== 64'hC0000000_80000000) begin
            errors++; $display("FAIL post_reset_result: got %h_%h expected %h", bus.hi, bus.lo, exp_v); end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] a, b;
        int          exp_n;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            b = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 17)) : $urandom);
            exp_n = (o == OP_MULT || o == OP_MULTU) ? 5 : ((o == OP_DIV || o == OP_DIVU) ? 10 : 0);
            issue(o, a, b, 1'b0, 1'b0);
            wait_idle(n);
            checks++; if (n != exp_n) begin errors++; $display("FAIL rand_cycles[%0d]: op=%0d got %0d expected %0d", i, o, n, exp_n); end
            exp_v = sb.pop_front();
            checks++; if ({bus.hi, bus.lo} !== exp_v) begin
                errors++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h_%h expected %h", i, o, a, b, bus.hi, bus.lo, exp_v); end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_divu_zero;
        test_mthi_mtlo;
        test_stall;
        test_kill;
        test_back_to_back;
        test_reset_abort;
        test_after_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
